// File: rtl/r_clk_level_ctrl_pkg.sv
// Shared constants for the read-domain FIFO controller: pointer width helper,
// synchronizer depth limits and flag reset values.
package r_clk_level_ctrl_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  localparam logic RST_EMPTY        = 1'b1;
  localparam logic RST_ALMOST_EMPTY = 1'b1;
  localparam logic RST_UNDERFLOW    = 1'b0;

  // Pointers carry one extra lap bit above the RAM address.
  function automatic int ptr_w(input int address_size);
    return address_size + 1;
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// N-bit binary to reflected Gray code conversion.
module binary_to_gray
  import r_clk_level_ctrl_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] i_bin,
  output logic [N-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/d_ff_async.sv
// Generic W-bit register with asynchronous active-low reset to RST_VAL.
module d_ff_async
  import r_clk_level_ctrl_pkg::*;
#(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_q <= RST_VAL;
    else          o_q <= i_d;
  end

endmodule

// File: rtl/gray_to_binary.sv
// N-bit reflected Gray code to binary conversion (inverse of binary_to_gray).
module gray_to_binary
  import r_clk_level_ctrl_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] i_gray,
  output logic [N-1:0] o_bin
);

  // b[i] = b[i+1] ^ g[i] unrolled into a prefix XOR to avoid a bit-level chain.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[N-1:i];
  end

endmodule

// File: rtl/r_clk_level_ctrl.sv
// Read-domain async FIFO controller: read pointer, synchronized write pointer,
// registered empty / almost-empty / fill level and a sticky underflow flag.
module r_clk_level_ctrl
  import r_clk_level_ctrl_pkg::*;
#(
  parameter int ADDRESS_SIZE = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    r_clk,
  input  logic                    rrst_n,
  input  logic                    r_en,
  input  logic [ADDRESS_SIZE:0]   w_ptr,
  input  logic [ADDRESS_SIZE:0]   r_ae_thresh,
  input  logic                    r_uf_clr,
  output logic [ADDRESS_SIZE-1:0] r_addr,
  output logic [ADDRESS_SIZE:0]   r_ptr,
  output logic                    r_inc,
  output logic                    r_empty,
  output logic                    r_almost_empty,
  output logic [ADDRESS_SIZE:0]   r_level,
  output logic                    r_underflow
);

  localparam int PTR_W = ptr_w(ADDRESS_SIZE);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("r_clk_level_ctrl: SYNC_STAGES out of range");
  end

  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] r_sync [SYNC_STAGES];
  logic [PTR_W-1:0] w_bnext;
  logic [PTR_W-1:0] w_gnext;
  logic [PTR_W-1:0] w_rq_wptr;
  logic [PTR_W-1:0] w_rq_wbin;
  logic [PTR_W-1:0] w_level_next;
  logic             w_empty_next;
  logic             w_ae_next;
  logic             w_uf_next;

  assign r_inc   = r_en & ~r_empty;
  assign w_bnext = r_bin + PTR_W'(r_inc);
  assign r_addr  = r_bin[ADDRESS_SIZE-1:0];

  binary_to_gray #(.N(PTR_W)) u_b2g (
    .i_bin  (w_bnext),
    .o_gray (w_gnext)
  );

  d_ff_async #(.W(PTR_W), .RST_VAL('0)) u_bin_reg (
    .i_clk   (r_clk),
    .i_rst_n (rrst_n),
    .i_d     (w_bnext),
    .o_q     (r_bin)
  );

  d_ff_async #(.W(PTR_W), .RST_VAL('0)) u_ptr_reg (
    .i_clk   (r_clk),
    .i_rst_n (rrst_n),
    .i_d     (w_gnext),
    .o_q     (r_ptr)
  );

  // Plain flop chain: nothing may sit between stages or the Gray property breaks.
  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    logic [PTR_W-1:0] w_d;
    if (g == 0) begin : g_first
      assign w_d = w_ptr;
    end else begin : g_next
      assign w_d = r_sync[g-1];
    end
    d_ff_async #(.W(PTR_W), .RST_VAL('0)) u_ff (
      .i_clk   (r_clk),
      .i_rst_n (rrst_n),
      .i_d     (w_d),
      .o_q     (r_sync[g])
    );
  end

  assign w_rq_wptr = r_sync[SYNC_STAGES-1];

  gray_to_binary #(.N(PTR_W)) u_g2b (
    .i_gray (w_rq_wptr),
    .o_bin  (w_rq_wbin)
  );

  // Stale write pointer can only under-report the level, never over-report.
  assign w_level_next = w_rq_wbin - w_bnext;
  assign w_empty_next = (w_gnext == w_rq_wptr);
  assign w_ae_next    = (w_level_next <= r_ae_thresh);
  assign w_uf_next    = (r_en & r_empty) | (r_underflow & ~r_uf_clr);

  d_ff_async #(.W(1), .RST_VAL(RST_EMPTY)) u_empty_reg (
    .i_clk   (r_clk),
    .i_rst_n (rrst_n),
    .i_d     (w_empty_next),
    .o_q     (r_empty)
  );

  d_ff_async #(.W(1), .RST_VAL(RST_ALMOST_EMPTY)) u_ae_reg (
    .i_clk   (r_clk),
    .i_rst_n (rrst_n),
    .i_d     (w_ae_next),
    .o_q     (r_almost_empty)
  );

  d_ff_async #(.W(PTR_W), .RST_VAL('0)) u_level_reg (
    .i_clk   (r_clk),
    .i_rst_n (rrst_n),
    .i_d     (w_level_next),
    .o_q     (r_level)
  );

  d_ff_async #(.W(1), .RST_VAL(RST_UNDERFLOW)) u_uf_reg (
    .i_clk   (r_clk),
    .i_rst_n (rrst_n),
    .i_d     (w_uf_next),
    .o_q     (r_underflow)
  );

endmodule

// File: tb/tb_r_clk_level_ctrl.sv
// Scoreboard bench for r_clk_level_ctrl (ADDRESS_SIZE=3, SYNC_STAGES=2) against
// a count-based FIFO model: level = writes seen after sync delay - reads done.
module tb_r_clk_level_ctrl;

  localparam int AS    = 3;
  localparam int SS    = 2;
  localparam int PW    = AS + 1;
  localparam int DEPTH = 8;

  logic          r_clk = 1'b0;
  logic          rrst_n = 1'b1;
  logic          r_en = 1'b0;
  logic          r_uf_clr = 1'b0;
  logic [PW-1:0] w_ptr = '0;
  logic [PW-1:0] r_ae_thresh = '0;
  logic [AS-1:0] r_addr;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_level;
  logic          r_inc, r_empty, r_almost_empty, r_underflow;

  always #5 r_clk = ~r_clk;

  r_clk_level_ctrl #(.ADDRESS_SIZE(AS), .SYNC_STAGES(SS)) dut (
    .r_clk          (r_clk),
    .rrst_n         (rrst_n),
    .r_en           (r_en),
    .w_ptr          (w_ptr),
    .r_ae_thresh    (r_ae_thresh),
    .r_uf_clr       (r_uf_clr),
    .r_addr         (r_addr),
    .r_ptr          (r_ptr),
    .r_inc          (r_inc),
    .r_empty        (r_empty),
    .r_almost_empty (r_almost_empty),
    .r_level        (r_level),
    .r_underflow    (r_underflow)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit empty;
    bit ae;
    int level;
    bit uf;
    int rb;
  } st_t;

  st_t sq[$];
  int  aq[$];
  bit  mon_en = 1'b0;
  st_t mon_s;

  // model state: plain counts of writes published and reads accepted
  int rcnt, wcnt, cur_w;
  bit cur_en, cur_clr, m_empty, m_uf;
  int hist[$];

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rcnt = 0; wcnt = 0; cur_w = 0;
    m_empty = 1'b1; m_uf = 1'b0;
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(0);
    sq.delete();
    aq.delete();
  endtask

  task automatic drive(input bit en, input int w, input bit clr);
    cur_en = en; cur_w = w; cur_clr = clr;
    r_en = en; w_ptr = gray(w); r_uf_clr = clr;
    if (en && !m_empty) aq.push_back(rcnt % DEPTH);
  endtask

  task automatic model_edge();
    bit rd;
    int lvl;
    st_t s;
    rd   = cur_en && !m_empty;
    m_uf = (cur_en && m_empty) || (m_uf && !cur_clr);
    if (rd) rcnt++;
    hist.push_back(cur_w);
    lvl = hist[0] - rcnt;
    void'(hist.pop_front());
    m_empty = (lvl == 0);
    s.empty = m_empty;
    s.ae    = (lvl <= int'(r_ae_thresh));
    s.level = lvl;
    s.uf    = m_uf;
    s.rb    = rcnt;
    sq.push_back(s);
  endtask

  task automatic step(input bit en, input int w, input bit clr);
    @(posedge r_clk);
    #1;
    model_edge();
    drive(en, w, clr);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, r_empty, 1);
    chk({tag, "_ae"}, r_almost_empty, 1);
    chk({tag, "_level"}, r_level, 0);
    chk({tag, "_addr"}, r_addr, 0);
    chk({tag, "_ptr"}, r_ptr, 0);
    chk({tag, "_uf"}, r_underflow, 0);
    chk({tag, "_inc"}, r_inc, 0);
  endtask

  always @(negedge r_clk) begin
    if (mon_en) begin
      if (sq.size() > 0) begin
        mon_s = sq.pop_front();
        chk("empty", r_empty, int'(mon_s.empty));
        chk("almost_empty", r_almost_empty, int'(mon_s.ae));
        chk("level", r_level, mon_s.level);
        chk("underflow", r_underflow, int'(mon_s.uf));
        chk("r_ptr", r_ptr, int'(gray(mon_s.rb)));
        chk("r_addr", r_addr, mon_s.rb % DEPTH);
      end
      if (r_inc === 1'b1) begin
        if (aq.size() == 0) chk("r_inc_unexpected", r_inc, 0);
        else                chk("read_addr", r_addr, aq.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    r_ae_thresh = PW'(2);
    drive(1'b1, 0, 1'b0);
    #1 rrst_n = 1'b0;
    #2 chk_reset_vals("reset");

    @(negedge r_clk); #1 rrst_n = 1'b1; mon_en = 1'b1;

    // read while empty sets underflow, then clear it
    repeat (2) step(1'b1, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);

    // three writes, Gray 0->1->3->2
    wcnt = 1; step(1'b0, wcnt, 1'b0);
    wcnt = 2; step(1'b0, wcnt, 1'b0);
    wcnt = 3; step(1'b0, wcnt, 1'b0);
    repeat (5) step(1'b0, wcnt, 1'b0);

    // full FIFO, then drain with continuous r_en
    wcnt = 8; step(1'b0, wcnt, 1'b0);
    repeat (3) step(1'b0, wcnt, 1'b0);
    repeat (12) step(1'b1, wcnt, 1'b0);

    // set and clear together: set wins; then clear alone
    step(1'b1, wcnt, 1'b1);
    step(1'b0, wcnt, 1'b1);
    repeat (2) step(1'b0, wcnt, 1'b0);

    // random traffic over 20+ pointer laps
    begin
      int lim;
      lim = wcnt + DEPTH * 21;
      for (int i = 0; i < 4000 && wcnt < lim; i++) begin
        if (i % 40 == 0) r_ae_thresh = PW'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 6 && wcnt < rcnt + DEPTH) wcnt++;
        step($urandom_range(0, 9) < 7, wcnt, $urandom_range(0, 19) == 0);
      end
      if (wcnt < lim) begin
        total++; bad++;
        $display("FAIL wrap_budget: got %0d writes expected %0d", wcnt, lim);
      end
    end

    // drain, then build level 5 and reset between edges
    begin
      bit drained;
      drained = 1'b0;
      for (int i = 0; i < 60 && !drained; i++) begin
        step(1'b1, wcnt, 1'b0);
        drained = (rcnt == wcnt);
      end
      if (!drained) begin
        total++; bad++;
        $display("FAIL drain_budget: got %0d reads expected %0d", rcnt, wcnt);
      end
    end
    step(1'b0, wcnt, 1'b1);
    r_ae_thresh = PW'(2);
    wcnt += 5;
    step(1'b0, wcnt, 1'b0);
    repeat (3) step(1'b0, wcnt, 1'b0);
    #2;
    chk("pre_reset_level", r_level, 5);
    mon_en = 1'b0;
    rrst_n = 1'b0;
    #1 chk_reset_vals("async_reset");

    model_reset();
    r_ae_thresh = PW'(0);
    drive(1'b0, 0, 1'b0);
    @(negedge r_clk); #1 rrst_n = 1'b1; mon_en = 1'b1;
    wcnt = 1; step(1'b0, wcnt, 1'b0);
    wcnt = 2; step(1'b0, wcnt, 1'b0);
    repeat (5) step(1'b1, wcnt, 1'b0);
    repeat (2) step(1'b0, wcnt, 1'b0);

    @(negedge r_clk); #1;
    chk("reads_outstanding", aq.size(), 0);
    chk("status_outstanding", sq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r_clk_level_ctrl.md
Name: r_clk_level_ctrl

Overview:
- Parametrised read-domain controller for the asynchronous FIFO. It is the successor to the basic read-pointer/empty block.
- Generates the binary read address, the Gray read pointer for the write domain, and a registered empty flag.
- Adds a configurable synchronizer depth, a read-side fill level, a programmable almost-empty flag and a sticky underflow flag.
- Sits in the r_clk domain between the dual-port RAM read port and the consumer.

Parameters:
- ADDRESS_SIZE, 4: RAM address width. FIFO depth is 2^ADDRESS_SIZE. Pointers are ADDRESS_SIZE+1 bits.
- SYNC_STAGES, 2: number of flops in the w_ptr synchronizer chain. Legal range 2..4.

Ports:
- r_clk  in  1  read-domain clock; the only clock.
- rrst_n  in  1  asynchronous active-low reset.
- r_en  in  1  consumer read request.
- w_ptr  in  ADDRESS_SIZE+1  Gray write pointer from the write domain (asynchronous to r_clk).
- r_ae_thresh  in  ADDRESS_SIZE+1  almost-empty threshold, quasi-static.
- r_uf_clr  in  1  clears the sticky underflow flag.
- r_addr  out  ADDRESS_SIZE  RAM read address.
- r_ptr  out  ADDRESS_SIZE+1  registered Gray read pointer, sent to the write domain.
- r_inc  out  1  accepted read this cycle (combinational).
- r_empty  out  1  registered empty flag.
- r_almost_empty  out  1  registered almost-empty flag.
- r_level  out  ADDRESS_SIZE+1  registered entry count, range 0..2^ADDRESS_SIZE.
- r_underflow  out  1  sticky underflow flag.

Behaviour:
- Clock and reset: one clock, r_clk. Reset rrst_n is asynchronous and active-low. All flops reset on the falling edge of rrst_n, independent of r_clk.
- Reset values: r_bin=0, r_ptr=0, all sync flops=0, r_empty=1, r_almost_empty=1, r_level=0, r_underflow=0.
- r_inc = r_en & !r_empty. A read while empty is ignored: the pointer holds.
- r_bnext = r_bin + r_inc, modulo 2^(ADDRESS_SIZE+1). Pointer wrap is natural roll-over, and the MSB toggles on each lap.
- r_addr = r_bin[ADDRESS_SIZE-1:0]. RAM data for the current address is valid in the same cycle as r_inc.
- r_gnext = binary_to_gray(r_bnext). r_ptr is registered from r_gnext, so exactly one bit changes per increment.
- Synchronizer: w_ptr passes through a SYNC_STAGES-deep flop chain to give rq_wptr. No logic sits between the stages.
- rq_wbin = gray_to_binary(rq_wptr).
- level_next = rq_wbin - r_bnext, modulo 2^(ADDRESS_SIZE+1).
- Registered updates, one r_clk edge after r_bnext:
  - r_empty <= (r_gnext == rq_wptr).
  - r_level <= level_next.
  - r_almost_empty <= (level_next <= r_ae_thresh).
- Latency:
  - A w_ptr change is reflected in r_empty, r_level and r_almost_empty after SYNC_STAGES+1 r_clk edges.
  - A read is reflected in those outputs at the next edge.
- Conservatism: r_level may under-report because of synchronizer lag. It never over-reports. r_empty may be pessimistic but is never falsely deasserted.
- Full FIFO: r_level = 2^ADDRESS_SIZE, meaning the MSBs differ and the lower bits are equal.
- Reading the last entry: r_en while r_level = 1 and no new write has been synchronized gives r_empty=1 at the next edge, and r_inc is 0 from then on.
- r_ae_thresh >= 2^ADDRESS_SIZE: r_almost_empty is permanently 1. r_ae_thresh = 0: r_almost_empty equals r_empty.
- Underflow:
  - r_underflow sets on any edge where r_en & r_empty.
  - r_uf_clr clears it.
  - If set and clear occur together, set wins.
- Reset mid-operation: all state returns to the reset values immediately, without a clock. The write side is required to reset its own pointer as well; cross-domain reset sequencing is outside this block.
- Deassertion of rrst_n is assumed to be synchronized to r_clk at the top level.

Decomposition:
- Shared package/header:
  - pointer-width localparam PTR_W = ADDRESS_SIZE+1;
  - SYNC_STAGES legal-range constants;
  - reset-value constants for the flags.
- New sub-module gray_to_binary, parameter N. It is the inverse of binary_to_gray: b[N-1]=g[N-1], b[i]=b[i+1]^g[i].
- Existing team cells are reused for the registers and the Gray conversion: d_ff_async and binary_to_gray.
- The synchronizer is a SYNC_STAGES-parametrised generalisation of the two-flop synchronizer, implemented as a generate loop inside this block.

Test Plan (ADDRESS_SIZE=3, SYNC_STAGES=2):
- Reset with w_ptr=0, r_en=1 -> r_empty=1, r_level=0, r_almost_empty=1, r_addr=0, r_ptr=0. r_underflow=1 after the first edge.
- w_ptr steps Gray 0->1->3->2 (3 writes), r_en=0, r_ae_thresh=2 -> r_empty falls 3 edges after the first step. r_level reaches 3 after the last step + 3 edges. r_almost_empty deasserts when r_level=3.
- Continuous r_en with w_ptr=Gray(8) (full, binary 1000) -> r_level starts at 8. r_addr counts 0..7, with 8 r_inc pulses. Then r_empty=1, r_ptr=Gray(8)=1100, and r_addr wraps to 0.
- Wrap: 20 write/read laps of 8 entries -> no false empty or level error at the MSB roll-over. r_level stays within 0..8, checked against a scoreboard model.
- r_en=1 and r_uf_clr=1 in the same cycle while empty -> r_underflow stays 1. r_uf_clr alone the next cycle -> r_underflow=0.
- Assert rrst_n=0 between clock edges mid-stream with r_level=5 -> all outputs take their reset values immediately, with no r_clk edge needed.
